lmul_seq: RTL and testbench
===========================

# lmul_seq

Multi-cycle sequencer for the long-multiply path (UMULL/SMULL). It takes two 32-bit operands and produces a 64-bit product with a radix-2 shift-add loop. The main control FSM holds its long-multiply write-back states (ALUWB then ALUWB2) until `done`, then writes `result_lo` and `result_hi` to the register file over two cycles. The block replaces the single-cycle 64-bit multiplier, so the multiply no longer sets the critical path.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. The product is 2·WIDTH bits.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low; 0 = reset.
- `start`  in  1: request a multiply. Sampled only in IDLE.
- `is_signed`  in  1: 1 = SMULL (two's complement), 0 = UMULL. Captured with `start`.
- `a`, `b`  in  WIDTH: operands, captured with `start`.
- `flush`  in  1: abort the current operation (instruction squashed).
- `busy`  out  1: high in RUN, FIX and DONE.
- `done`  out  1: one-cycle pulse, high in DONE only.
- `result_lo`  out  WIDTH: product bits [WIDTH-1:0].
- `result_hi`  out  WIDTH: product bits [2·WIDTH-1:WIDTH].

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE, `start`=1:
  - Latch `mcand` = |a| and `mplier` = |b|. The absolute value applies only when `is_signed`=1; otherwise the raw operand is used.
  - Latch `neg` = is_signed & (a[W-1] ^ b[W-1]).
  - Clear the accumulator and set `cnt` = 0. Go to RUN.
- RUN, one iteration per cycle:
  - If `mplier`[0], add `mcand` to the upper half of the accumulator, with carry into bit 2W.
  - Shift {carry, acc} right by 1. Shift `mplier` right by 1. Increment `cnt`.
  - After WIDTH iterations go to FIX.
- FIX: if `neg`, the product register becomes the two's-complement negation of the accumulator (2W bits); otherwise it is copied unchanged. Go to DONE.
- DONE: `done`=1. Go to IDLE next cycle.
- `result_lo`/`result_hi` come from a dedicated product register, loaded only in FIX. They hold their value until the next FIX, which also covers the two write-back cycles after `done`.
- Arithmetic:
  - |0x80000000| = 0x80000000, treated as unsigned in the magnitude path.
  - Only the final 2W-bit result is truncated. The RUN adder is W+1 bits wide.
- `start` in RUN/FIX/DONE is ignored; there is no queueing.
- `flush`:
  - In RUN or FIX, the next state is IDLE, with no `done` and no product update.
  - In DONE, `flush` has no effect; `done` still pulses.
  - `flush` together with `start` in IDLE: `flush` wins and nothing is captured.
- Reset (`reset`=0), at any time including mid-operation:
  - State = IDLE, `busy`=0, `done`=0.
  - Product register, accumulator, `cnt` and `neg` = 0, so `result_lo` = `result_hi` = 0.

## Timing
- Latency: `start` is sampled at edge E0. State is RUN from E0 through E(WIDTH). FIX after E(WIDTH). DONE after E(WIDTH+1).
  - Concretely, `done` is high in the cycle after edge E(WIDTH+1), which is 34 cycles after the start cycle for WIDTH=32.
- `busy` rises the cycle after `start` is sampled. It falls the cycle after DONE.
- Throughput: a new `start` is accepted in the IDLE cycle after DONE, so operations are spaced WIDTH+3 cycles apart.
- Outputs are registered or decoded from the state only. There is no combinational path from any input to any output.
- `cnt` width is $clog2(WIDTH+1). The terminal test is `cnt` == WIDTH-1 during RUN.

## Structure
- The shared control package holds:
  - the state encodings (LMUL_IDLE=0, LMUL_RUN=1, LMUL_FIX=2, LMUL_DONE=3);
  - the default WIDTH.
- One natural sub-module, `lmul_core`: the datapath. It holds the accumulator, the shifted multiplier, the W+1-bit adder, the negation and the product register. Its controls are `load`, `step` and `fix`.
- `lmul_seq` contains the FSM, `cnt` and the `flush`/`start` arbitration.
- The main FSM's long-multiply path gains a wait-on-`done` hold. Its ALUWB/ALUWB2 selects then read `result_lo` and `result_hi` respectively.

## Test plan
- Unsigned max: a=b=0xFFFFFFFF, is_signed=0 → `done` exactly 34 cycles after the start cycle; result_hi=0xFFFFFFFE, result_lo=0x00000001.
- Signed mixed: a=0xFFFFFFFD (−3), b=5, is_signed=1 → result_hi=0xFFFFFFFF, result_lo=0xFFFFFFF1.
- Signed corner: a=b=0x80000000, is_signed=1 → result_hi=0x40000000, result_lo=0. Also −1×−1 → hi=0, lo=1.
- Start while busy: second `start` (a=2, b=3) at cycle 10 of a 7×9 operation → single `done` with lo=63; no second `done` until a new `start` in IDLE.
- Flush: assert `flush` at RUN cycle 15 → IDLE next cycle, no `done`, result registers keep their previous value. A following start of 4×4 gives lo=16.
- Async reset: drop `reset` at RUN cycle 20 → `busy`/`done`/results are 0 immediately (no clock edge needed). Release, then 6×7 → lo=42 with full latency.

Source files
------------

// File: rtl/lmul_pkg.sv
// Shared control definitions for the sequential long-multiply path.
package lmul_pkg;

  // Default operand width; the product is twice this wide.
  localparam int unsigned LMUL_WIDTH = 32;

  typedef enum logic [1:0] {
    LMUL_IDLE = 2'd0,
    LMUL_RUN  = 2'd1,
    LMUL_FIX  = 2'd2,
    LMUL_DONE = 2'd3
  } lmul_state_e;

endpackage

// File: rtl/lmul_core.sv
// Radix-2 shift-add datapath: magnitude capture, accumulate/shift, sign fix-up, product register.
module lmul_core
  import lmul_pkg::*;
#(
  parameter int unsigned WIDTH = LMUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod;
  logic               neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;

  // Operand magnitudes and the W+1-bit partial-product adder.
  // The most negative value maps onto itself, which is correct when read as unsigned.
  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  end

  // Accumulator and multiplier: load clears, each step adds then shifts {carry, acc} right.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
    end else if (load) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      acc    <= '0;
      neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc    <= {sum, acc[WIDTH-1:1]};
      mplier <= mplier >> 1;
    end
  end

  // Product register: only updated on the fix-up cycle so write-back sees stable data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod <= '0;
    end else if (fix) begin
      prod <= neg ? -acc : acc;
    end
  end

  assign result_lo = prod[WIDTH-1:0];
  assign result_hi = prod[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/lmul_seq.sv
// Long-multiply sequencer: control FSM, iteration counter and start/flush arbitration.
module lmul_seq
  import lmul_pkg::*;
#(
  parameter int unsigned WIDTH = LMUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  lmul_state_e      state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             load, step, fix;
  logic             last_iter;

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LMUL_IDLE;
    else        state <= state_next;
  end

  // Next state and datapath controls; flush overrides start and suppresses any update.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    unique case (state)
      LMUL_IDLE: begin
        if (start && !flush) begin
          load       = 1'b1;
          state_next = LMUL_RUN;
        end
      end
      LMUL_RUN: begin
        if (flush) begin
          state_next = LMUL_IDLE;
        end else begin
          step = 1'b1;
          if (last_iter) state_next = LMUL_FIX;
        end
      end
      LMUL_FIX: begin
        state_next = LMUL_IDLE;
        if (!flush) begin
          fix        = 1'b1;
          state_next = LMUL_DONE;
        end
      end
      LMUL_DONE: state_next = LMUL_IDLE;
      default:   state_next = LMUL_IDLE;
    endcase
  end

  // Iteration counter, cleared on load and advanced once per RUN step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + 1'b1;
  end

  // Status outputs decode the registered state only.
  always_comb begin
    busy = (state != LMUL_IDLE);
    done = (state == LMUL_DONE);
  end

  lmul_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .fix       (fix),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .result_lo (result_lo),
    .result_hi (result_hi)
  );

endmodule

// File: tb/tb_lmul_seq.sv
// Directed bench for lmul_seq: vector table plus start-while-busy, flush and async reset sequences.
module tb_lmul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  vec_t vecs[11];

  lmul_seq #(
    .WIDTH(32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete operation: start pulse, bounded wait for done, latency and result checks.
  task automatic run_op(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input string name);
    int lat = 0;
    bit seen = 0;
    @(negedge clk);
    start = 1'b1; is_signed = sgn; a = x; b = y;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat == 1) check({name, " busy"}, 64'(busy), 64'd1);
      if (done) seen = 1;
    end
    check({name, " latency"}, seen ? 64'(lat) : 64'd0, 64'd34);
    check({name, " product"}, {result_hi, result_lo}, exp);
    @(negedge clk);
    check({name, " done pulse"}, {63'd0, done}, 64'd0);
    check({name, " product hold"}, {result_hi, result_lo}, exp);
  endtask

  initial begin
    int dones;
    int first_lat;

    vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[1]  = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[2]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[3]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[4]  = '{1'b0, 32'h0000_0007, 32'h0000_0009, 64'h0000_0000_0000_003F};
    vecs[5]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2};
    vecs[6]  = '{1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
    vecs[8]  = '{1'b0, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[10] = '{1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 64'h0000_0004_FFFF_FFF1};

    reset = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", {result_hi, result_lo}, 64'd0);
    reset = 1'b1;

    for (int v = 0; v < 11; v++) begin
      run_op(vecs[v].sgn, vecs[v].a, vecs[v].b, vecs[v].prod, $sformatf("vec%0d", v));
    end

    // Second start during RUN must be ignored: exactly one done, carrying 7*9.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 32'd7; b = 32'd9;
    dones = 0; first_lat = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      start = (i == 10);
      if (i == 10) begin a = 32'd2; b = 32'd3; end
      if (done) begin
        dones++;
        if (first_lat == 0) first_lat = i;
      end
    end
    start = 1'b0;
    check("busy-start done count", 64'(dones), 64'd1);
    check("busy-start latency", 64'(first_lat), 64'd34);
    check("busy-start product", {result_hi, result_lo}, 64'd63);

    // Flush in RUN: back to IDLE next cycle, no done, product untouched.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 32'h1234; b = 32'h5678;
    dones = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      flush = (i == 15);
      if (i == 16) check("flush busy drop", 64'(busy), 64'd0);
      if (done) dones++;
    end
    flush = 1'b0;
    check("flush no done", 64'(dones), 64'd0);
    check("flush product kept", {result_hi, result_lo}, 64'd63);
    run_op(1'b0, 32'd4, 32'd4, 64'd16, "after flush");

    // Flush together with start in IDLE: nothing is captured.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush+start busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("flush+start product", {result_hi, result_lo}, 64'd16);

    // Asynchronous reset mid-RUN clears status and results without a clock edge.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; a = 32'd3; b = 32'd3;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset done", 64'(done), 64'd0);
    check("async reset product", {result_hi, result_lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(1'b0, 32'd6, 32'd7, 64'd42, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
